// File: rtl/rs_ldst_ord_ctrl_pkg.sv
// Shared types and helpers for the load/store RS allocation/issue controller.
// Entry count comes from RS_LDST_ENT_NUM / RS_LDST_ENT_SEL when defined.
`ifndef RS_LDST_ENT_NUM
`define RS_LDST_ENT_NUM 2
`endif
`ifndef RS_LDST_ENT_SEL
`define RS_LDST_ENT_SEL 1
`endif
package rs_ldst_ord_ctrl_pkg;

  localparam int ENT_NUM = `RS_LDST_ENT_NUM;
  localparam int ENT_SEL = `RS_LDST_ENT_SEL;
  localparam int CNT_W = $clog2(ENT_NUM + 1);

  typedef logic [ENT_SEL-1:0] idx_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef struct packed {
    logic ok_1;
    idx_t sel_1;
    logic ok_2;
    idx_t sel_2;
  } pick_t;

  // Circular pointer advance by 0..2 slots.
  function automatic idx_t ptr_add(idx_t p, logic [1:0] n);
    logic [ENT_SEL+1:0] s;
    s = {2'b00, p} + {{ENT_SEL{1'b0}}, n};
    if (s >= (ENT_SEL+2)'(ENT_NUM))
      s = s - (ENT_SEL+2)'(ENT_NUM);
    return s[ENT_SEL-1:0];
  endfunction

  // Lowest and second-lowest free entry.
  function automatic pick_t pick_free(logic [ENT_NUM-1:0] free);
    pick_t r;
    r = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (free[i]) begin
        if (!r.ok_1) begin
          r.ok_1  = 1'b1;
          r.sel_1 = idx_t'(i);
        end else if (!r.ok_2) begin
          r.ok_2  = 1'b1;
          r.sel_2 = idx_t'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ldst_age_fifo.sv
// Age queue of RS entry indices: dual push (slot 1 first), single pop.
// clr empties the queue at the next edge and overrides push/pop.
module ldst_age_fifo
  import rs_ldst_ord_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push_1,
  input  logic push_2,
  input  idx_t d_1,
  input  idx_t d_2,
  input  logic pop,
  output idx_t head_idx,
  output cnt_t count
);

  idx_t       q [ENT_NUM];
  idx_t       head;
  idx_t       tail;
  logic [1:0] npush;
  idx_t       wr_2;

  assign npush    = {1'b0, push_1} + {1'b0, push_2};
  assign wr_2     = push_1 ? ptr_add(tail, 2'd1) : tail;
  assign head_idx = q[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ENT_NUM; i++)
        q[i] <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_1)
        q[tail] <= d_1;
      if (push_2)
        q[wr_2] <= d_2;
      tail  <= ptr_add(tail, npush);
      if (pop)
        head <= ptr_add(head, 2'd1);
      count <= count + cnt_t'(npush) - cnt_t'(pop);
    end
  end

endmodule

// File: rtl/rs_ldst_ord_ctrl.sv
// Load/store RS allocation and strictly in-order issue controller.
// Optional RS_LDST_FLUSH_EN adds i_flush to drop all queued entries.
module rs_ldst_ord_ctrl
  import rs_ldst_ord_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ENT_NUM-1:0] i_busy_vec,
  input  logic [ENT_NUM-1:0] i_vld_vec,
  input  logic               i_dp_req_1,
  input  logic               i_dp_req_2,
  input  logic               i_stall_ext,
  input  logic               i_ex_rdy,
`ifdef RS_LDST_FLUSH_EN
  input  logic               i_flush,
`endif
  output logic               o_stall_req,
  output logic               o_alloc_vld_1,
  output idx_t               o_alloc_sel_1,
  output logic               o_alloc_vld_2,
  output idx_t               o_alloc_sel_2,
  output logic               o_is_vld,
  output idx_t               o_is_sel
);

  logic  flush;
  pick_t pk;
  logic  short;
  logic  push_1;
  logic  push_2;
  idx_t  head_idx;
  cnt_t  q_cnt;

`ifdef RS_LDST_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  assign pk = pick_free(~i_busy_vec);

  // Not enough free entries for every requesting slot.
  assign short = (i_dp_req_1 & i_dp_req_2 & ~pk.ok_2) |
                 ((i_dp_req_1 ^ i_dp_req_2) & ~pk.ok_1);

  assign o_stall_req   = short & ~flush;
  assign o_alloc_vld_1 = i_dp_req_1 & ~short & ~flush;
  assign o_alloc_vld_2 = i_dp_req_2 & ~short & ~flush;
  assign o_alloc_sel_1 = o_alloc_vld_1 ? pk.sel_1 : '0;
  assign o_alloc_sel_2 = !o_alloc_vld_2 ? '0 :
                         i_dp_req_1     ? pk.sel_2 : pk.sel_1;

  assign push_1 = o_alloc_vld_1 & ~i_stall_ext;
  assign push_2 = o_alloc_vld_2 & ~i_stall_ext;

  assign o_is_vld = (q_cnt != '0) & i_vld_vec[head_idx] &
                    i_ex_rdy & ~flush;
  assign o_is_sel = o_is_vld ? head_idx : '0;

  ldst_age_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push_1   (push_1),
    .push_2   (push_2),
    .d_1      (o_alloc_sel_1),
    .d_2      (o_alloc_sel_2),
    .pop      (o_is_vld),
    .head_idx (head_idx),
    .count    (q_cnt)
  );

endmodule

// File: tb/tb_rs_ldst_ord_ctrl.sv
// Directed and model-checked bench for rs_ldst_ord_ctrl (ENT_NUM=2).
// Set RS_LDST_FLUSH_EN to include the flush sequence.
module tb_rs_ldst_ord_ctrl;
  import rs_ldst_ord_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] i_busy_vec;
  logic [1:0] i_vld_vec;
  logic       i_dp_req_1;
  logic       i_dp_req_2;
  logic       i_stall_ext;
  logic       i_ex_rdy;
  logic       o_stall_req;
  logic       o_alloc_vld_1;
  idx_t       o_alloc_sel_1;
  logic       o_alloc_vld_2;
  idx_t       o_alloc_sel_2;
  logic       o_is_vld;
  idx_t       o_is_sel;
`ifdef RS_LDST_FLUSH_EN
  logic       i_flush;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rs_ldst_ord_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_busy_vec    (i_busy_vec),
    .i_vld_vec     (i_vld_vec),
    .i_dp_req_1    (i_dp_req_1),
    .i_dp_req_2    (i_dp_req_2),
    .i_stall_ext   (i_stall_ext),
    .i_ex_rdy      (i_ex_rdy),
`ifdef RS_LDST_FLUSH_EN
    .i_flush       (i_flush),
`endif
    .o_stall_req   (o_stall_req),
    .o_alloc_vld_1 (o_alloc_vld_1),
    .o_alloc_sel_1 (o_alloc_sel_1),
    .o_alloc_vld_2 (o_alloc_vld_2),
    .o_alloc_sel_2 (o_alloc_sel_2),
    .o_is_vld      (o_is_vld),
    .o_is_sel      (o_is_sel)
  );

  typedef struct {
    logic [1:0] busy;
    logic       r1;
    logic       r2;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [12];
  int   qm [$];
  logic [1:0] bm;

  // {stall, vld1, sel1, vld2, sel2, is_vld, is_sel}
  function automatic logic [6:0] obs();
    return {o_stall_req, o_alloc_vld_1, o_alloc_sel_1,
            o_alloc_vld_2, o_alloc_sel_2, o_is_vld, o_is_sel};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] busy, input logic r1,
                       input logic r2, input logic sx,
                       input logic [1:0] vld, input logic ex);
    i_busy_vec  = busy;
    i_dp_req_1  = r1;
    i_dp_req_2  = r2;
    i_stall_ext = sx;
    i_vld_vec   = vld;
    i_ex_rdy    = ex;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{2'b00, 1'b1, 1'b1, 7'b0101100};
    tbl[1]  = '{2'b00, 1'b1, 1'b0, 7'b0100000};
    tbl[2]  = '{2'b00, 1'b0, 1'b1, 7'b0001000};
    tbl[3]  = '{2'b01, 1'b1, 1'b1, 7'b1000000};
    tbl[4]  = '{2'b01, 1'b1, 1'b0, 7'b0110000};
    tbl[5]  = '{2'b01, 1'b0, 1'b1, 7'b0001100};
    tbl[6]  = '{2'b10, 1'b1, 1'b1, 7'b1000000};
    tbl[7]  = '{2'b10, 1'b0, 1'b1, 7'b0001000};
    tbl[8]  = '{2'b11, 1'b1, 1'b0, 7'b1000000};
    tbl[9]  = '{2'b11, 1'b0, 1'b0, 7'b0000000};
    tbl[10] = '{2'b00, 1'b0, 1'b0, 7'b0000000};
    tbl[11] = '{2'b10, 1'b1, 1'b0, 7'b0100000};

`ifdef RS_LDST_FLUSH_EN
    i_flush = 1'b0;
`endif
    rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1);
    #3;
    chk("reset_out", obs(), 7'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("post_reset_no_issue", obs(), 7'd0);
    cyc();

    // Allocation table; stall_ext keeps the queue empty throughout.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].busy, tbl[i].r1, tbl[i].r2, 1'b1, 2'b11, 1'b1);
      #2;
      chk($sformatf("tbl_%0d", i), obs(), tbl[i].exp);
      cyc();
    end

    // Dual dispatch then back-to-back issue.
    drive(2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1); #2;
    chk("dual_alloc", obs(), 7'b0101100); cyc();
    drive(2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1); #2;
    chk("dual_iss0", obs(), 7'b0000010); cyc();
    drive(2'b10, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1); #2;
    chk("dual_iss1", obs(), 7'b0000011); cyc();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1); #2;
    chk("dual_empty", obs(), 7'd0); cyc();

    // Entry 1 older than entry 0; blocked head holds the ready younger one.
    drive(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1); #2;
    chk("ord_alloc1", obs(), 7'b0110000); cyc();
    drive(2'b10, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1); #2;
    chk("ord_alloc0_blk", obs(), 7'b0100000); cyc();
    drive(2'b11, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1); #2;
    chk("ord_blk", obs(), 7'd0); cyc();
    drive(2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1); #2;
    chk("ord_iss1", obs(), 7'b0000011); cyc();
    drive(2'b01, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1); #2;
    chk("ord_iss0", obs(), 7'b0000010); cyc();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1); #2;
    chk("ord_empty", obs(), 7'd0); cyc();

    // Stall: no push while stalled or externally stalled.
    drive(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1); #2;
    chk("stl_push", obs(), 7'b0100000); cyc();
    drive(2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1); #2;
    chk("stl_stall", obs(), 7'b1000000); cyc();
    drive(2'b01, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1); #2;
    chk("stl_req2", obs(), 7'b0001100); cyc();
    drive(2'b01, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1); #2;
    chk("stl_cnt", dut.u_fifo.count, 1);
    chk("stl_iss0", obs(), 7'b0000010); cyc();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1); #2;
    chk("stl_cnt0", dut.u_fifo.count, 0);
    chk("stl_empty", obs(), 7'd0); cyc();

`ifdef RS_LDST_FLUSH_EN
    drive(2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1); cyc();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1);
    i_flush = 1'b1; #2;
    chk("fl_cnt2", dut.u_fifo.count, 2);
    chk("fl_out", obs(), 7'd0); cyc();
    i_flush = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1); #2;
    chk("fl_cnt0", dut.u_fifo.count, 0);
    chk("fl_idle", obs(), 7'd0); cyc();
`endif

    // Random traffic against a reference queue and busy model.
    bm = 2'b00;
    for (int c = 0; c < 30; c++) begin
      logic r1, r2, sx, ex, est, ev1, ev2, eiv;
      logic [1:0] vv, pm, im;
      int fl [2];
      int nf, es1, es2, eis;
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      sx = ($urandom_range(0, 3) == 0);
      ex = ($urandom_range(0, 3) != 0);
      vv = 2'($urandom_range(0, 3));
      nf = 0; fl[0] = 0; fl[1] = 0;
      for (int i = 0; i < 2; i++)
        if (!bm[i]) begin fl[nf] = i; nf++; end
      est = nf < (int'(r1) + int'(r2));
      ev1 = r1 && !est;
      ev2 = r2 && !est;
      es1 = ev1 ? fl[0] : 0;
      es2 = ev2 ? (r1 ? fl[1] : fl[0]) : 0;
      eiv = (qm.size() != 0) && vv[qm[0]] && ex;
      eis = eiv ? qm[0] : 0;
      drive(bm, r1, r2, sx, vv, ex);
      #2;
      chk("rnd_out", obs(),
          {est, ev1, 1'(es1), ev2, 1'(es2), eiv, 1'(eis)});
      chk("rnd_cnt", dut.u_fifo.count, qm.size());
      if (o_is_vld)
        chk("rnd_head_busy", bm[o_is_sel], 1);
      pm = '0; im = '0;
      if (eiv) begin
        void'(qm.pop_front());
        im[eis] = 1'b1;
      end
      if (ev1 && !sx) begin qm.push_back(es1); pm[es1] = 1'b1; end
      if (ev2 && !sx) begin qm.push_back(es2); pm[es2] = 1'b1; end
      bm = (bm & ~im) | pm;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
